conv2d_window_gen: RTL and testbench
====================================

Name: conv2d_window_gen

Overview:
- Upstream feeder for conv2d: accepts a raster-order pixel stream, one pixel per handshake, and emits every fully-populated 3x3 window ("valid" convolution, no padding).
- Each window is presented flattened, in the same 0..8 ordering as the conv2d kernel taps, with a ready/valid handshake so downstream stalls propagate back to the source.
- Storage is two line buffers of IMG_W entries plus a 3x3 window shift register.

Parameters:
- IMG_W, 5, image width in pixels; must be >= 3.
- IMG_H, 5, image height in pixels; must be >= 3.
- DATA_W, 8, pixel width in bits.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  DATA_W  pixel, raster order, row 0 first.
- in_ready  out  1  block accepts in_data this cycle.
- win_valid  out  1  win_data holds a complete window.
- win_ready  in  1  downstream accepts the window this cycle.
- win_data  out  9*DATA_W  window; slice k=(3*i+j) is pixel (row R+i, col C+j), so k=0 is top-left.
- win_row  out  $clog2(IMG_H)  R, the window's top-left row.
- win_col  out  $clog2(IMG_W)  C, the window's top-left column.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse when the last window is accepted.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - state=IDLE.
  - in_ready, win_valid, busy and frame_done are all 0.
  - win_data, win_row, win_col and the pixel row/col counters are 0.
  - Line-buffer contents need not be cleared.
- FSM:
  - IDLE -> STREAM on start.
  - STREAM -> FLUSH after accepting pixel (IMG_H-1, IMG_W-1).
  - FLUSH -> IDLE on the cycle the final window handshakes (win_valid&&win_ready); frame_done=1 on that same cycle.
  - start while not IDLE is ignored.
- Input handshake:
  - in_ready = (state==STREAM) && (!win_valid || win_ready).
  - A pixel transfers when in_valid && in_ready.
  - in_data is ignored when no transfer occurs; gaps in in_valid are allowed.
- Pixel accept:
  - Each accepted pixel shifts into the line buffers and the window register.
  - The col counter advances, wrapping 0 after IMG_W-1, with a row increment.
- Window emission:
  - Triggered when the accepted pixel is at (r,c) with r>=2 and c>=2.
  - On the next cycle: win_valid=1, win_row=r-2, win_col=c-2, and win_data holds pixels rows r-2..r, cols c-2..c.
  - Latency is 1 cycle from the completing input handshake.
  - Windows never span a row wrap: columns 0 and 1 of each row produce no window.
- Output hold:
  - While win_valid && !win_ready, win_data, win_row and win_col are held stable and in_ready=0.
  - win_valid drops after a handshake unless a new window loads in the same cycle (back-to-back allowed at full rate).
- Window count: exactly (IMG_H-2)*(IMG_W-2) per frame, in raster order of (R,C); 9 for 5x5.
- No arithmetic is performed; data passes through unmodified, no width change.
- Reset mid-frame: the frame is abandoned, outputs return to reset values next cycle, and a new start is required.
- Simultaneous start and rst: rst wins.

Test Plan:
1. 5x5 ramp 1..25, in_valid continuous, win_ready=1:
   - 9 windows, first win_data = {1,2,3,6,7,8,11,12,13} with (R,C)=(0,0); last = {13,14,15,18,19,20,23,24,25} with (2,2).
   - frame_done pulses once; busy returns to 0.
   - Summing all window taps gives 1053.
2. Same stream, win_ready toggled 1-of-3 cycles:
   - win_data stable while stalled; in_ready low during stalls.
   - Identical 9-window sequence; no loss or duplication.
3. Same stream with random in_valid gaps: identical windows and coordinates as scenario 1.
4. start pulsed mid-frame: ignored, output unchanged. rst asserted after pixel 14: win_valid=0 and busy=0 next cycle; a fresh 5x5 frame then yields scenario 1 results.
5. Two frames back-to-back, second frame ramp 101..125: second frame first window = {101,102,103,106,107,108,111,112,113}; no stale pixels from frame 1.
6. IMG_W=6, IMG_H=4 ramp 1..24: 8 windows; first = {1,2,3,7,8,9,13,14,15}; last (R,C)=(1,3) = {10,11,12,16,17,18,22,23,24}.

Source files
------------

// File: rtl/conv2d_window_gen.sv
// conv2d_window_gen: turns a raster-order pixel stream into the stream of
// fully-populated 3x3 windows ("valid" convolution, no padding) feeding conv2d.
//
// Handshakes (both ports): a beat transfers on a rising clk edge where
// valid && ready is high. The source holds data while valid && !ready.
// in_ready does not depend on in_valid. win_valid does not depend on win_ready.
//
// Window layout: win_data[k*DATA_W +: DATA_W] with k = 3*i + j holds pixel
// (row R+i, col C+j), where (R,C) = (win_row, win_col). k=0 is the top-left pixel.
module conv2d_window_gen #(
  parameter int IMG_W  = 5,
  parameter int IMG_H  = 5,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic [9*DATA_W-1:0]        win_data,
  output logic [$clog2(IMG_H)-1:0]   win_row,
  output logic [$clog2(IMG_W)-1:0]   win_col,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_n;

  logic [ROW_W-1:0]   r_row;
  logic [COL_W-1:0]   r_col;

  // r_lb0 holds the previous row, r_lb1 the row before it, indexed by column.
  logic [DATA_W-1:0]  r_lb0 [IMG_W];
  logic [DATA_W-1:0]  r_lb1 [IMG_W];

  // r_win[i][j]: window row i (0 = oldest), column j (2 = newest).
  logic [DATA_W-1:0]  r_win [3][3];

  logic               r_win_valid;
  logic [ROW_W-1:0]   r_win_row;
  logic [COL_W-1:0]   r_win_col;

  logic               w_in_fire;
  logic               w_win_fire;
  logic               w_last_px;
  logic               w_load;
  logic [DATA_W-1:0]  w_top;
  logic [DATA_W-1:0]  w_mid;

  // Input is taken only while streaming and the output slot is free or draining.
  assign in_ready   = (r_state == S_STREAM) && (!r_win_valid || win_ready);
  assign w_in_fire  = in_valid && in_ready;
  assign w_win_fire = r_win_valid && win_ready;
  assign w_last_px  = (r_row == ROW_LAST) && (r_col == COL_LAST);
  // A pixel at row >= 2, col >= 2 completes the window whose bottom-right it is.
  assign w_load     = w_in_fire && (r_row >= ROW_TWO) && (r_col >= COL_TWO);
  assign w_top      = r_lb1[r_col];
  assign w_mid      = r_lb0[r_col];

  assign busy       = (r_state != S_IDLE);
  assign frame_done = (r_state == S_FLUSH) && w_win_fire;
  assign win_valid  = r_win_valid;
  assign win_row    = r_win_row;
  assign win_col    = r_win_col;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  // Next-state: IDLE -> STREAM on start, STREAM -> FLUSH after last pixel,
  // FLUSH -> IDLE when the final window is accepted.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_n = S_STREAM;
      S_STREAM: if (w_in_fire && w_last_px) w_state_n = S_FLUSH;
      S_FLUSH:  if (w_win_fire) w_state_n = S_IDLE;
      default:  w_state_n = S_IDLE;
    endcase
  end

  // Raster position of the next pixel; wraps to (0,0) after the last one.
  always_ff @(posedge clk) begin
    if (rst || (r_state == S_IDLE && start)) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_in_fire) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Line buffers: push the column through two rows of history.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_lb1[r_col] <= r_lb0[r_col];
      r_lb0[r_col] <= in_data;
    end
  end

  // Window shift register: each row shifts left, the new column enters on the right.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          r_win[i][j] <= '0;
    end else if (w_in_fire) begin
      for (int i = 0; i < 3; i++) begin
        r_win[i][0] <= r_win[i][1];
        r_win[i][1] <= r_win[i][2];
      end
      r_win[0][2] <= w_top;
      r_win[1][2] <= w_mid;
      r_win[2][2] <= in_data;
    end
  end

  // Output valid and coordinates; a new window may replace one being accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_valid <= 1'b0;
      r_win_row   <= '0;
      r_win_col   <= '0;
    end else if (w_load) begin
      r_win_valid <= 1'b1;
      r_win_row   <= r_row - ROW_TWO;
      r_win_col   <= r_col - COL_TWO;
    end else if (w_win_fire) begin
      r_win_valid <= 1'b0;
    end
  end

  // Flatten the window register into the kernel-tap ordering.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        win_data[(3*i+j)*DATA_W +: DATA_W] = r_win[i][j];
  end

endmodule

// File: tb/tb_conv2d_window_gen.sv
// Bench for conv2d_window_gen: a 5x5 instance and a 6x4 instance share the
// stimulus wires; a table of frame scenarios plus random frames are checked
// against a window list computed directly from the frame image.
module tb_conv2d_window_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        win_ready = 1'b1;

  logic        a_in_ready, a_win_valid, a_busy, a_frame_done;
  logic [71:0] a_win_data;
  logic [2:0]  a_win_row, a_win_col;
  logic        b_in_ready, b_win_valid, b_busy, b_frame_done;
  logic [71:0] b_win_data;
  logic [1:0]  b_win_row;
  logic [2:0]  b_win_col;

  always #5 clk = ~clk;

  conv2d_window_gen #(.IMG_W(5), .IMG_H(5), .DATA_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_data(in_data),
    .in_ready(a_in_ready), .win_valid(a_win_valid), .win_ready(win_ready),
    .win_data(a_win_data), .win_row(a_win_row), .win_col(a_win_col),
    .busy(a_busy), .frame_done(a_frame_done)
  );

  conv2d_window_gen #(.IMG_W(6), .IMG_H(4), .DATA_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_data(in_data),
    .in_ready(b_in_ready), .win_valid(b_win_valid), .win_ready(win_ready),
    .win_data(b_win_data), .win_row(b_win_row), .win_col(b_win_col),
    .busy(b_busy), .frame_done(b_frame_done)
  );

  // Selected-DUT view
  int          sel = 0;
  logic        m_in_ready, m_win_valid, m_busy, m_frame_done;
  logic [71:0] m_data;
  logic [3:0]  m_row, m_col;

  always_comb begin
    if (sel == 0) begin
      m_in_ready = a_in_ready; m_win_valid = a_win_valid; m_busy = a_busy;
      m_frame_done = a_frame_done; m_data = a_win_data;
      m_row = 4'(a_win_row); m_col = 4'(a_win_col);
    end else begin
      m_in_ready = b_in_ready; m_win_valid = b_win_valid; m_busy = b_busy;
      m_frame_done = b_frame_done; m_data = b_win_data;
      m_row = 4'(b_win_row); m_col = 4'(b_win_col);
    end
  end

  typedef struct {
    int          dut;        // 0: 5x5, 1: 6x4
    int          base;       // ramp start value; -1 = random pixels
    int          gap_pct;    // percent of cycles with in_valid low
    int          stall_mode; // 0: ready always, 1: ready 1 of 3, 2: random
    int          start_at;   // pixel count at which to pulse start again (-1 none)
    int          abort_at;   // pixel count after which rst is applied (-1 none)
    int          exp_count;  // expected windows (-1 skip)
    int          exp_sum;    // expected sum of all taps (-1 skip)
    bit          chk_ends;
    logic [71:0] exp_first;
    logic [71:0] exp_last;
    int          exp_last_row;
    int          exp_last_col;
  } vec_t;

  vec_t        tv[7];
  int          errors = 0;
  int          checks = 0;
  logic [79:0] exp_q[$];
  int          img[36];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic check_reset(input string name);
    check({name, "_in_ready"},   80'(m_in_ready),   80'd0);
    check({name, "_win_valid"},  80'(m_win_valid),  80'd0);
    check({name, "_busy"},       80'(m_busy),       80'd0);
    check({name, "_frame_done"}, 80'(m_frame_done), 80'd0);
    check({name, "_win_data"},   80'(m_data),       80'd0);
    check({name, "_win_rc"},     80'({m_row, m_col}), 80'd0);
  endtask

  // Reference: every full 3x3 window of the image, in raster order of (R,C).
  task automatic build_expected(input int w, input int h);
    logic [71:0] d;
    exp_q.delete();
    for (int r = 0; r + 2 < h; r++)
      for (int c = 0; c + 2 < w; c++) begin
        d = '0;
        for (int k = 0; k < 9; k++)
          d[k*8 +: 8] = 8'(img[(r + k/3) * w + c + (k % 3)]);
        exp_q.push_back({4'(r), 4'(c), d});
      end
  endtask

  task automatic run_frame(input string name, input vec_t v);
    int w, h, n, pix, cyc, nwin, sum, done_cnt;
    bit finished, aborted, restarted;
    logic [71:0] first_d, last_d;
    logic [3:0]  last_r, last_c;
    logic [79:0] act;
    sel = v.dut;
    w = (v.dut == 0) ? 5 : 6;
    h = (v.dut == 0) ? 5 : 4;
    n = w * h;
    for (int i = 0; i < n; i++)
      img[i] = (v.base >= 0) ? v.base + i : int'($urandom_range(0, 255));
    build_expected(w, h);
    pix = 0; cyc = 0; nwin = 0; sum = 0; done_cnt = 0;
    finished = 0; aborted = 0; restarted = 0;
    first_d = '0; last_d = '0; last_r = '0; last_c = '0;

    @(negedge clk);
    in_valid = 1'b0;
    win_ready = 1'b1;
    if (v.dut == 0) start_a = 1'b1; else start_b = 1'b1;

    while (!finished && !aborted && cyc < 3000) begin
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      if (v.start_at >= 0 && pix == v.start_at && !restarted) begin
        restarted = 1;
        if (v.dut == 0) start_a = 1'b1; else start_b = 1'b1;
      end
      in_valid = (pix < n) && ($urandom_range(0, 99) >= v.gap_pct);
      in_data  = in_valid ? 8'(img[pix]) : 8'($urandom);
      case (v.stall_mode)
        0:       win_ready = 1'b1;
        1:       win_ready = (cyc % 3 == 2);
        default: win_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      check({name, "_busy"}, 80'(m_busy), 80'd1);
      check({name, "_frame_done"}, 80'(m_frame_done),
            80'(m_win_valid && win_ready && exp_q.size() == 1));
      if (m_win_valid) begin
        act = {m_row, m_col, m_data};
        if (exp_q.size() == 0) begin
          check({name, "_extra_window"}, act, 80'd0);
        end else begin
          check({name, "_window"}, act, exp_q[0]);
        end
        if (!win_ready) check({name, "_in_ready_stall"}, 80'(m_in_ready), 80'd0);
        if (win_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          if (nwin == 0) first_d = m_data;
          last_d = m_data; last_r = m_row; last_c = m_col;
          for (int k = 0; k < 9; k++) sum += int'(m_data[k*8 +: 8]);
          nwin++;
          if (exp_q.size() == 0) finished = 1;
        end
      end
      if (m_frame_done) done_cnt++;
      if (in_valid && m_in_ready) pix++;
      if (v.abort_at >= 0 && pix == v.abort_at) aborted = 1;
      cyc++;
      @(posedge clk);
    end

    if (!finished && !aborted)
      check({name, "_timeout"}, 80'(cyc), 80'd0);

    if (aborted) begin
      // rst and start together: rst must win.
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; win_ready = 1'b1;
      if (v.dut == 0) start_a = 1'b1; else start_b = 1'b1;
      @(negedge clk);
      rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
      #1;
      check_reset({name, "_abort"});
      exp_q.delete();
    end else begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check({name, "_busy_end"}, 80'(m_busy), 80'd0);
      check({name, "_valid_end"}, 80'(m_win_valid), 80'd0);
      check({name, "_in_ready_end"}, 80'(m_in_ready), 80'd0);
      check({name, "_done_pulses"}, 80'(done_cnt), 80'd1);
      check({name, "_leftover"}, 80'(exp_q.size()), 80'd0);
      if (v.exp_count >= 0) check({name, "_count"}, 80'(nwin), 80'(v.exp_count));
      if (v.exp_sum >= 0)   check({name, "_sum"}, 80'(sum), 80'(v.exp_sum));
      if (v.chk_ends) begin
        check({name, "_first"}, 80'(first_d), 80'(v.exp_first));
        check({name, "_last"}, 80'(last_d), 80'(v.exp_last));
        check({name, "_last_rc"}, 80'({last_r, last_c}),
              80'({4'(v.exp_last_row), 4'(v.exp_last_col)}));
      end
    end
  endtask

  initial begin
    vec_t rv;
    //        dut base gap stall st_at ab_at cnt sum  ends first                     last                      lr lc
    tv[0] = '{0,  1,   0,  0,    -1,   -1,   9,  1053, 1, 72'h0d0c0b_080706_030201, 72'h191817_141312_0f0e0d, 2, 2};
    tv[1] = '{0,  1,   0,  1,    -1,   -1,   9,  1053, 1, 72'h0d0c0b_080706_030201, 72'h191817_141312_0f0e0d, 2, 2};
    tv[2] = '{0,  1,   35, 0,    10,   -1,   9,  1053, 1, 72'h0d0c0b_080706_030201, 72'h191817_141312_0f0e0d, 2, 2};
    tv[3] = '{0,  1,   0,  0,    7,    14,   -1, -1,   0, 72'h0,                    72'h0,                    0, 0};
    tv[4] = '{0,  1,   0,  0,    -1,   -1,   9,  1053, 1, 72'h0d0c0b_080706_030201, 72'h191817_141312_0f0e0d, 2, 2};
    tv[5] = '{0,  101, 0,  0,    -1,   -1,   9,  9153, 1, 72'h71706f_6c6b6a_676665, 72'h7d7c7b_787776_737271, 2, 2};
    tv[6] = '{1,  1,   0,  0,    -1,   -1,   8,  900,  1, 72'h0f0e0d_090807_030201, 72'h181716_121110_0c0b0a, 1, 3};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    sel = 0; #1; check_reset("reset_a");
    sel = 1; #1; check_reset("reset_b");

    for (int i = 0; i < 7; i++)
      run_frame($sformatf("vec%0d", i), tv[i]);

    for (int i = 0; i < 6; i++) begin
      rv = tv[0];
      rv.dut        = $urandom_range(0, 1);
      rv.base       = -1;
      rv.gap_pct    = $urandom_range(0, 60);
      rv.stall_mode = 2;
      rv.start_at   = $urandom_range(0, 15);
      rv.exp_count  = (rv.dut == 0) ? 9 : 8;
      rv.exp_sum    = -1;
      rv.chk_ends   = 0;
      run_frame($sformatf("rand%0d", i), rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
